sc_fetch_unit: RTL

Instruction-fetch stage directly upstream of the single-cycle control unit. Holds the PC and fetches from a variable-latency instruction memory with a req/ack handshake. Presents the latched instruction and its op/func fields to the control unit. Consumes the control unit's pcsource to form the next PC, gating each instruction's execute cycle with exec_en.

---
 rtl/sc_fetch_pkg.sv | 21 ++
 rtl/sc_npc_mux.sv | 36 +++
 rtl/sc_fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/sc_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch controller states
//   PCSRC_*       : pcsource encodings driven by the control unit
//   NOP_INST      : instruction word loaded on reset (sll $0,$0,0)
package sc_fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/sc_npc_mux.sv
// Combinational next-PC calculator.
//   pc4      : current pc + 4
//   inst     : latched instruction (imm16 for branches, idx26 for jumps)
//   ra       : rs register value, jr target
//   pcsource : PCSRC_SEQ / PCSRC_BR / PCSRC_JR / PCSRC_J
//   npc      : selected next PC, modulo 2^32
module sc_npc_mux
  import sc_fetch_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] inst,
  input  logic [31:0] ra,
  input  logic [1:0]  pcsource,
  output logic [31:0] npc
);

  logic [31:0] br_off;
  logic        unused_bits;

  assign br_off = {{14{inst[15]}}, inst[15:0], 2'b00};

  // opcode bits and the low bits of a misaligned jr target play no part
  assign unused_bits = ^{inst[31:26], ra[1:0]};

  always_comb begin
    npc = pc4;
    case (pcsource)
      PCSRC_SEQ: npc = pc4;
      PCSRC_BR:  npc = pc4 + br_off;
      PCSRC_JR:  npc = {ra[31:2], 2'b00};
      PCSRC_J:   npc = {pc4[31:28], inst[25:0], 2'b00};
      default:   npc = pc4;
    endcase
  end

endmodule

// File: rtl/sc_fetch_unit.sv
// Instruction-fetch stage feeding the single-cycle control unit.
// Holds the PC, fetches over a req/ack handshake with a timeout, and
// gives each latched instruction one exec_en cycle.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   REQ   | imem_req high at pc, waiting for imem_ack (timer counts misses)
//   EXEC  | inst valid, exec_en high, pc <= npc at end of cycle
//   HALT  | idle after an instruction while halt is held high
//   ERR   | memory timeout; all strobes low until reset
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   imem_req/addr/ack/rdata : instruction memory handshake
//   inst, op, func          : latched instruction and its fields
//   pc, pc4                 : current pc and pc + 4
//   exec_en                 : one-cycle execute strobe per instruction
//   pcsource, ra            : next-PC select and jr target
//   halt                    : stop after the current instruction
//   fetch_err               : sticky timeout flag
module sc_fetch_unit
  import sc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        exec_en,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  input  logic        halt,
  output logic        fetch_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  fetch_state_e  state;
  logic [TW-1:0] timer;
  logic [31:0]   npc;

  sc_npc_mux u_npc_mux (
    .pc4      (pc4),
    .inst     (inst),
    .ra       (ra),
    .pcsource (pcsource),
    .npc      (npc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= REQ;
      pc        <= RESET_PC;
      inst      <= NOP_INST;
      timer     <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (imem_ack) begin
            inst  <= imem_rdata;
            timer <= '0;
            state <= EXEC;
          end else if (timer == TIMER_LAST) begin
            // last permitted request cycle went unanswered
            fetch_err <= 1'b1;
            state     <= ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        EXEC: begin
          pc    <= npc;
          state <= halt ? HALT : REQ;
        end
        HALT: begin
          if (!halt) state <= REQ;
        end
        ERR: begin
          state <= ERR;
        end
        default: state <= ERR;
      endcase
    end
  end

  // strobes are masked by reset so nothing fires while reset is held
  assign imem_req  = (state == REQ)  && !reset;
  assign exec_en   = (state == EXEC) && !reset;
  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  assign op        = inst[31:26];
  assign func      = inst[5:0];

endmodule
